s_mem_arbiter: RTL and testbench

S_MEM_ARBITER -- requirements
Module: s_mem_arbiter

---
 rtl/s_mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_s_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: three-way arbiter in front of the single-port 256x8 S memory.
// Requesters: 0 = init, 1 = ksa, 2 = prga. The owner's beats are steered to the
// memory combinationally; read returns are tagged with the issuing requester
// and delivered READ_LATENCY cycles after the beat.
//
// Build option: define S_ARB_ROUND_ROBIN_EN for round-robin arbitration
// (search upward from the requester after the last granted one). Left
// undefined, arbitration is fixed priority init > ksa > prga.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner, gnt = 0, any req is arbitrated this cycle
// OWNED | exactly one gnt bit set; owner keeps it while req or lock is high

module s_mem_arbiter #(
    parameter int READ_LATENCY = 1      // 1 or 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      req,
    input  logic [2:0]      lock,
    input  logic [2:0][7:0] addr_i,
    input  logic [2:0][7:0] wdata_i,
    input  logic [2:0]      wren_i,
    output logic [2:0]      gnt,
    output logic [7:0]      rdata,
    output logic [2:0]      rvalid,
    output logic [7:0]      mem_address,
    output logic [7:0]      mem_data,
    output logic            mem_wren,
    input  logic [7:0]      mem_q,
    output logic            busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic       arb_en;
    logic [2:0] cand;
    logic [2:0] win;

    logic [1:0] own_idx;
    logic       beat;
    logic [2:0] rd_tag;

    // One-hot tag per pipeline stage; stage READ_LATENCY-1 drives rvalid.
    logic [READ_LATENCY-1:0][2:0] tag_q;

`ifdef S_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;     // index of the last granted requester
`endif

    function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

`ifdef S_ARB_ROUND_ROBIN_EN
    // Search starts at the requester after 'last' and wraps.
    function automatic logic [2:0] pick_winner(input logic [2:0] c, input logic [1:0] last);
        logic [2:0] w;
        w = 3'b000;
        case (last)
            2'd0: begin
                if      (c[1]) w = 3'b010;
                else if (c[2]) w = 3'b100;
                else if (c[0]) w = 3'b001;
            end
            2'd1: begin
                if      (c[2]) w = 3'b100;
                else if (c[0]) w = 3'b001;
                else if (c[1]) w = 3'b010;
            end
            default: begin
                if      (c[0]) w = 3'b001;
                else if (c[1]) w = 3'b010;
                else if (c[2]) w = 3'b100;
            end
        endcase
        return w;
    endfunction
`else
    function automatic logic [2:0] pick_winner(input logic [2:0] c);
        logic [2:0] w;
        w = 3'b000;
        if      (c[0]) w = 3'b001;
        else if (c[1]) w = 3'b010;
        else if (c[2]) w = 3'b100;
        return w;
    endfunction
`endif

    // Next owner: arbitrate from IDLE, or on release hand straight to another requester.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        arb_en  = 1'b0;
        cand    = 3'b000;
`ifdef S_ARB_ROUND_ROBIN_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                arb_en = 1'b1;
                cand   = req;
            end
            ST_OWNED: begin
                // lock only matters for the current owner
                if (!(|(gnt_q & (req | lock)))) begin
                    arb_en = 1'b1;
                    cand   = req & ~gnt_q;
                end
            end
            default: begin
                arb_en = 1'b1;
                cand   = req;
            end
        endcase

`ifdef S_ARB_ROUND_ROBIN_EN
        win = pick_winner(cand, rr_ptr_q);
`else
        win = pick_winner(cand);
`endif

        if (arb_en) begin
            if (|win) begin
                state_d = ST_OWNED;
                gnt_d   = win;
`ifdef S_ARB_ROUND_ROBIN_EN
                rr_ptr_d = onehot_idx(win);
`endif
            end else begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
        end
    end

    // State and grant registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef S_ARB_ROUND_ROBIN_EN
    // Last-granted pointer; reset to 2 so the first search starts at init.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= 2'd2;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Owner's beat steered to memory; anything else leaves the bus at zero.
    always_comb begin
        own_idx     = onehot_idx(gnt_q);
        beat        = |(gnt_q & req);
        mem_wren    = 1'b0;
        mem_address = 8'h00;
        mem_data    = 8'h00;
        rd_tag      = 3'b000;
        if (beat) begin
            mem_address = addr_i[own_idx];
            mem_data    = wdata_i[own_idx];
            mem_wren    = wren_i[own_idx];
            if (!wren_i[own_idx]) begin
                rd_tag = gnt_q;
            end
        end
    end

    // Read-return tag pipeline; carries the issuer so later grant changes do not matter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= rd_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = tag_q[READ_LATENCY-1];
    assign rdata  = mem_q;
    assign busy   = (|gnt_q) | (|tag_q);

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Testbench for s_mem_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model; read returns go through a
// scoreboard queue drained by an independent monitor.
module tb_s_mem_arbiter;

    localparam int LAT = 1;

    logic            clk;
    logic            reset_n;
    logic [2:0]      req, lock, wren_i;
    logic [2:0][7:0] addr_i, wdata_i;
    logic [2:0]      gnt, rvalid;
    logic [7:0]      rdata, mem_address, mem_data, mem_q;
    logic            mem_wren, busy;

    s_mem_arbiter #(.READ_LATENCY(LAT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .lock        (lock),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wren_i      (wren_i),
        .gnt         (gnt),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous S memory with LAT-cycle read latency.
    logic [7:0] sram [256];
    logic [7:0] rd1, rd2;
    always @(posedge clk) begin
        if (mem_wren) sram[mem_address] <= mem_data;
        rd1 <= sram[mem_address];
        rd2 <= rd1;
    end
    assign mem_q = (LAT == 2) ? rd2 : rd1;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         due;
        logic [2:0] tag;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: owner index (-1 = none), last granted, memory contents.
    int         m_owner;
    int         m_last;
    int         m_last_due;
    logic [7:0] m_mem [256];

    logic [2:0] obs_gnt;
    logic       obs_wren;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [2:0] c);
`ifdef S_ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= 3; i++) begin
            int j;
            j = (m_last + i) % 3;
            if (c[j]) return j;
        end
`else
        for (int i = 0; i < 3; i++) begin
            if (c[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner    = -1;
        m_last     = 2;
        m_last_due = -1;
        exp_q.delete();
    endtask

    // One clock cycle of stimulus: drive, check combinational/registered outputs, advance model.
    task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                         input logic [2:0][7:0] a, input logic [2:0][7:0] d);
        logic [2:0] eg;
        logic       bt;
        logic [7:0] ea, ed;
        logic       ew;
        @(negedge clk);
        req = r; lock = l; wren_i = w; addr_i = a; wdata_i = d;
        #1;
        eg = 3'b000;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        bt = (m_owner >= 0) && r[m_owner];
        ea = bt ? a[m_owner] : 8'h00;
        ed = bt ? d[m_owner] : 8'h00;
        ew = bt ? w[m_owner] : 1'b0;
        obs_gnt  = gnt;
        obs_wren = mem_wren;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("mem_wren", 32'(mem_wren), 32'(ew));
        chk("mem_address", 32'(mem_address), 32'(ea));
        chk("mem_data", 32'(mem_data), 32'(ed));
        chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_last_due >= cyc)));
        if (bt) begin
            if (ew) begin
                m_mem[ea] = ed;
            end else begin
                exp_q.push_back('{due: cyc + LAT, tag: eg, data: m_mem[ea]});
                m_last_due = cyc + LAT;
            end
        end
        if (!(m_owner >= 0 && (r[m_owner] || l[m_owner]))) begin
            m_owner = pick(r);
            if (m_owner >= 0) m_last = m_owner;
        end
    endtask

    task automatic d_simple(input logic [2:0] r, input logic [2:0] l);
        drive(r, l, 3'b000, '0, '0);
    endtask

    // Read-return monitor: pops the scoreboard whenever rvalid is presented or an entry is overdue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rvalid !== 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("rv_unexpected", 32'(rvalid), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rv_cycle", 32'(cyc), 32'(e.due));
                    chk("rv_tag", 32'(rvalid), 32'(e.tag));
                    chk("rdata", 32'(rdata), 32'(e.data));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("rv_missing", 32'(rvalid), 32'(e.tag));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [2:0][7:0] a, d;
    int wr_count;
    logic [2:0] g_exp [4];

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]  = 8'h00;
            m_mem[i] = 8'h00;
        end
        reset_n = 1'b0;
        req = '0; lock = '0; wren_i = '0; addr_i = '0; wdata_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_gnt", 32'(gnt), 32'(0));
        chk("reset_rvalid", 32'(rvalid), 32'(0));
        chk("reset_wren", 32'(mem_wren), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // All three request right after reset, then successive releases.
`ifdef S_ARB_ROUND_ROBIN_EN
        g_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        g_exp = '{3'b001, 3'b010, 3'b001, 3'b001};
`endif
        d_simple(3'b111, 3'b000);
        d_simple(3'b110, 3'b000); chk("arb_seq0", 32'(obs_gnt), 32'(g_exp[0]));
        d_simple(3'b101, 3'b000); chk("arb_seq1", 32'(obs_gnt), 32'(g_exp[1]));
        d_simple(3'b011, 3'b000); chk("arb_seq2", 32'(obs_gnt), 32'(g_exp[2]));
        d_simple(3'b000, 3'b000); chk("arb_seq3", 32'(obs_gnt), 32'(g_exp[3]));
        repeat (3) d_simple(3'b000, 3'b000);

        // Init fills S[i] = i.
        a = '0; d = '0;
        drive(3'b001, 3'b000, 3'b001, a, d);
        wr_count = 0;
        for (int i = 0; i < 256; i++) begin
            a[0] = 8'(i); d[0] = 8'(i);
            drive(3'b001, 3'b000, 3'b001, a, d);
            if (obs_wren) wr_count++;
        end
        chk("init_wren_count", 32'(wr_count), 32'(256));

        // KSA under lock with prga waiting.
        d_simple(3'b110, 3'b010);
        a = '0; d = '0;
        a[1] = 8'h05; drive(3'b110, 3'b010, 3'b000, a, d); chk("ksa_g0", 32'(obs_gnt), 32'(3'b010));
        a[1] = 8'h0A; drive(3'b110, 3'b010, 3'b000, a, d); chk("ksa_g1", 32'(obs_gnt), 32'(3'b010));
        a[1] = 8'h05; d[1] = 8'hA5; drive(3'b110, 3'b010, 3'b010, a, d); chk("ksa_g2", 32'(obs_gnt), 32'(3'b010));
        a[1] = 8'h0A; d[1] = 8'h5A; drive(3'b110, 3'b010, 3'b010, a, d); chk("ksa_g3", 32'(obs_gnt), 32'(3'b010));
        d_simple(3'b100, 3'b010); chk("ksa_lock_hold", 32'(obs_gnt), 32'(3'b010));
        d_simple(3'b100, 3'b000); chk("ksa_release", 32'(obs_gnt), 32'(3'b010));
        d_simple(3'b100, 3'b000); chk("prga_handoff", 32'(obs_gnt), 32'(3'b100));

        // Read by init, then handoff to prga before the return.
        d_simple(3'b001, 3'b000);
        a = '0; d = '0; a[0] = 8'h10;
        drive(3'b001, 3'b000, 3'b000, a, d); chk("init_own", 32'(obs_gnt), 32'(3'b001));
        d_simple(3'b100, 3'b000);
        d_simple(3'b100, 3'b000); chk("handoff_gnt", 32'(obs_gnt), 32'(3'b100));

        // Non-owner write while init holds by lock.
        d_simple(3'b001, 3'b000);
        d_simple(3'b001, 3'b000);
        a = '0; d = '0; a[2] = 8'h33; d[2] = 8'hEE;
        drive(3'b100, 3'b001, 3'b100, a, d);
        chk("nonowner_gnt", 32'(obs_gnt), 32'(3'b001));
        chk("nonowner_wren", 32'(obs_wren), 32'(0));
        d_simple(3'b000, 3'b000);
        d_simple(3'b000, 3'b000);
        chk("s33_unchanged", 32'(sram[8'h33]), 32'(m_mem[8'h33]));

        // Reset one cycle after a read beat discards the return.
        d_simple(3'b001, 3'b000);
        a = '0; d = '0; a[0] = 8'h20;
        drive(3'b001, 3'b000, 3'b000, a, d);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        req = '0; lock = '0;
        model_reset();
        #1;
        chk("rst_mid_rvalid", 32'(rvalid), 32'(0));
        chk("rst_mid_gnt", 32'(gnt), 32'(0));
        chk("rst_mid_wren", 32'(mem_wren), 32'(0));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        d_simple(3'b110, 3'b000);
        d_simple(3'b110, 3'b000); chk("post_rst_gnt", 32'(obs_gnt), 32'(3'b010));
        repeat (3) d_simple(3'b000, 3'b000);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [2:0] r, l, w;
            r = 3'($urandom_range(0, 7));
            l = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            w = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                a[k] = 8'($urandom_range(0, 255));
                d[k] = 8'($urandom_range(0, 255));
            end
            drive(r, l, w, a, d);
        end

        repeat (LAT + 4) d_simple(3'b000, 3'b000);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        for (int i = 0; i < 256; i++) begin
            if (sram[i] !== m_mem[i]) chk("mem_final", 32'(sram[i]), 32'(m_mem[i]));
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
